// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encodings and sizing helpers for the serializer
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } ser_state_e;

  localparam int GAP_CNT_W = 4;

  function automatic int bit_cnt_w(input int data_w);
    return ($clog2(data_w) > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - word-in handshake and serial-out bundle
interface piso_serializer_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_out,
    output ser_valid,
    output busy
  );

endinterface

// File: rtl/piso_serializer_shreg.sv
// rtl/piso_serializer_shreg.sv - loadable shift register; load with shift applies one shift to the loaded word
module piso_shreg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              head_o
);

  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    src     = load_i ? din_i : sh_q;
    shifted = MSB_FIRST ? {src[DATA_W-2:0], 1'b0} : {1'b0, src[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= '0;
    end else if (load_i || shift_i) begin
      sh_q <= shift_i ? shifted : src;
    end
  end

  assign head_o = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out stage with idle gap and fixed idle fill
module piso_serializer
  import ser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic             clk,
  input logic             reset_n,
  piso_serializer_if.slave bus
);

  localparam int                   CW       = bit_cnt_w(DATA_W);
  localparam logic [CW-1:0]        LAST_BIT = CW'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit                   HAS_GAP  = (GAP > 0);

  ser_state_e           state_q;
  logic [CW-1:0]        bit_cnt_q;
  logic [GAP_CNT_W-1:0] gap_cnt_q;
  logic                 ser_out_q;
  logic                 ser_valid_q;

  logic last_bit;
  logic in_ready;
  logic xfer;
  logic first_bit;
  logic sh_shift;
  logic sh_head;

  assign last_bit = (bit_cnt_q == LAST_BIT);

  // Ready is held low while reset is asserted even though the state reads IDLE.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = reset_n;
      ST_SHIFT: in_ready = reset_n && !HAS_GAP && last_bit;
      default:  in_ready = 1'b0;
    endcase
  end

  assign xfer      = bus.in_valid && in_ready;
  assign first_bit = MSB_FIRST ? bus.in_data[DATA_W-1] : bus.in_data[0];
  assign sh_shift  = xfer || ((state_q == ST_SHIFT) && !last_bit);

  // The register runs one bit ahead of ser_out_q, so its head is always the next bit to present.
  piso_shreg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (xfer),
    .shift_i (sh_shift),
    .din_i   (bus.in_data),
    .head_o  (sh_head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            state_q     <= ST_SHIFT;
            bit_cnt_q   <= '0;
            ser_out_q   <= first_bit;
            ser_valid_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!last_bit) begin
            bit_cnt_q   <= bit_cnt_q + CW'(1);
            ser_out_q   <= sh_head;
            ser_valid_q <= 1'b1;
          end else if (xfer) begin
            bit_cnt_q   <= '0;
            ser_out_q   <= first_bit;
            ser_valid_q <= 1'b1;
          end else if (HAS_GAP) begin
            state_q     <= ST_GAP;
            gap_cnt_q   <= GAP_LOAD;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
          end else begin
            state_q     <= ST_IDLE;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
          end
        end
        ST_GAP: begin
          ser_out_q   <= IDLE_BIT;
          ser_valid_q <= 1'b0;
          if (gap_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_CNT_W'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          bit_cnt_q   <= '0;
          gap_cnt_q   <= '0;
          ser_out_q   <= IDLE_BIT;
          ser_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_GAP);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - three serializer configurations checked against a per-cycle output timeline
module tb_piso_serializer;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  piso_serializer_if #(.DATA_W(8)) if_a ();
  piso_serializer_if #(.DATA_W(8)) if_b ();
  piso_serializer_if #(.DATA_W(8)) if_c ();

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) dut_a (
    .clk (clk), .reset_n (reset_n), .bus (if_a.slave));
  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .GAP(0), .IDLE_BIT(1'b0)) dut_b (
    .clk (clk), .reset_n (reset_n), .bus (if_b.slave));
  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP(3), .IDLE_BIT(1'b1)) dut_c (
    .clk (clk), .reset_n (reset_n), .bus (if_c.slave));

  bit   cfg_msb  [3] = '{1'b1, 1'b0, 1'b1};
  int   cfg_gap  [3] = '{0, 0, 3};
  bit   cfg_idle [3] = '{1'b0, 1'b0, 1'b1};

  int   n_checks = 0;
  int   n_errors = 0;
  int   sel      = 0;
  int   cyc      = 0;
  bit   rnd      = 1'b0;

  // Each entry is {valid, bit} for one upcoming cycle; an empty queue means idle.
  logic [1:0] pend [$];
  logic [7:0] tx_q [$];
  int         xfer_cyc [$];

  logic obs_out, obs_valid, obs_busy, obs_ready;
  logic outs [10];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (dut %0d, cycle %0d): got %0h expected %0h", tag, sel, cyc, got, exp);
    end
  endtask

  task automatic sample();
    case (sel)
      0: begin obs_out = if_a.ser_out; obs_valid = if_a.ser_valid; obs_busy = if_a.busy; obs_ready = if_a.in_ready; end
      1: begin obs_out = if_b.ser_out; obs_valid = if_b.ser_valid; obs_busy = if_b.busy; obs_ready = if_b.in_ready; end
      default: begin obs_out = if_c.ser_out; obs_valid = if_c.ser_valid; obs_busy = if_c.busy; obs_ready = if_c.in_ready; end
    endcase
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if_a.in_valid = v && (sel == 0);
    if_b.in_valid = v && (sel == 1);
    if_c.in_valid = v && (sel == 2);
    if_a.in_data  = d;
    if_b.in_data  = d;
    if_c.in_data  = d;
  endtask

  task automatic step();
    logic       v;
    logic       rdy_exp;
    logic [1:0] head;
    logic [7:0] d;
    logic [7:0] w;
    @(negedge clk);
    sample();
    head    = (pend.size() > 0) ? pend[0] : {1'b0, cfg_idle[sel]};
    rdy_exp = (pend.size() == 0) || (pend.size() == 1 && pend[0][1] && cfg_gap[sel] == 0);
    check_eq("ser_valid", 32'(obs_valid), 32'(head[1]));
    check_eq("ser_out",   32'(obs_out),   32'(head[0]));
    check_eq("busy",      32'(obs_busy),  32'(pend.size() > 0));
    check_eq("in_ready",  32'(obs_ready), 32'(rdy_exp));
    v = (tx_q.size() > 0) && (!rnd || $urandom_range(3) != 0);
    d = v ? tx_q[0] : 8'($urandom);
    drive(v, d);
    if (v && obs_ready) xfer_cyc.push_back(cyc);
    if (pend.size() > 0) void'(pend.pop_front());
    if (v && rdy_exp) begin
      w = tx_q.pop_front();
      for (int i = 0; i < 8; i++) pend.push_back({1'b1, cfg_msb[sel] ? w[7-i] : w[i]});
      for (int g = 0; g < cfg_gap[sel]; g++) pend.push_back({1'b0, cfg_idle[sel]});
    end
    cyc++;
  endtask

  task automatic run_collect();
    for (int i = 0; i < 10; i++) begin
      step();
      outs[i] = obs_out;
    end
  endtask

  initial begin
    logic [8:0] mask;
    logic [7:0] stream;
    int         vcnt, rcnt, guard;

    drive(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      sample();
      check_eq("rst_ser_out",   32'(obs_out),   32'(cfg_idle[s]));
      check_eq("rst_ser_valid", 32'(obs_valid), 32'd0);
      check_eq("rst_busy",      32'(obs_busy),  32'd0);
      check_eq("rst_in_ready",  32'(obs_ready), 32'd0);
    end
    reset_n = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      sample();
      check_eq("rel_in_ready", 32'(obs_ready), 32'd1);
    end

    // MSB-first 0x99 and the 1001 pattern a chained detector would flag.
    sel = 0; rnd = 1'b0;
    tx_q.push_back(8'h99);
    run_collect();
    stream = '0;
    for (int k = 1; k <= 8; k++) stream = {stream[6:0], outs[k]};
    check_eq("msb_stream", 32'(stream), 32'h99);
    mask = '0;
    for (int k = 4; k <= 8; k++)
      if ({outs[k-3], outs[k-2], outs[k-1], outs[k]} == 4'b1001) mask[k] = 1'b1;
    check_eq("det_op_cycles", 32'(mask), 32'h110);

    // LSB-first 0xA0.
    sel = 1;
    tx_q.push_back(8'hA0);
    run_collect();
    stream = '0;
    for (int k = 1; k <= 8; k++) stream = {stream[6:0], outs[k]};
    check_eq("lsb_stream", 32'(stream), 32'h05);
    check_eq("lsb_c9_valid_drop", 32'(outs[9]), 32'd0);

    // Back-to-back with no gap: 16 contiguous valid cycles, ready at 0, 8 and 16.
    sel = 0;
    tx_q.push_back(8'hF0);
    tx_q.push_back(8'h0F);
    vcnt = 0; rcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_valid) vcnt++;
      if (obs_ready && i <= 16) rcnt++;
    end
    check_eq("nogap_valid_cycles", 32'(vcnt), 32'd16);
    check_eq("nogap_ready_cycles", 32'(rcnt), 32'd3);

    // Gap of three with idle-high fill.
    sel = 2;
    xfer_cyc.delete();
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hC5);
    for (int i = 0; i < 30; i++) step();
    check_eq("gap_xfer_count", 32'(xfer_cyc.size()), 32'd2);
    if (xfer_cyc.size() == 2)
      check_eq("gap_word_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd12);

    // Reset pulsed in the middle of a word.
    sel = 0;
    tx_q.push_back(8'hFF);
    for (int i = 0; i < 5; i++) step();
    check_eq("pre_rst_bit4", 32'(obs_out), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    sample();
    check_eq("midrst_ser_out",   32'(obs_out),   32'd0);
    check_eq("midrst_ser_valid", 32'(obs_valid), 32'd0);
    check_eq("midrst_busy",      32'(obs_busy),  32'd0);
    check_eq("midrst_in_ready",  32'(obs_ready), 32'd0);
    pend.delete();
    tx_q.delete();
    drive(1'b0, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    sample();
    check_eq("postrst_in_ready", 32'(obs_ready), 32'd1);
    for (int i = 0; i < 10; i++) step();

    // Random words with random valid bubbles and garbage data between words.
    for (int s = 0; s < 3; s++) begin
      sel = s; rnd = 1'b1;
      for (int i = 0; i < 16; i++) tx_q.push_back(8'($urandom));
      guard = 0;
      while ((tx_q.size() > 0 || pend.size() > 0) && guard < 2000) begin
        step();
        guard++;
      end
      check_eq("random_drain", 32'(tx_q.size() + pend.size()), 32'd0);
      for (int i = 0; i < 3; i++) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
